// File: rtl/snes_pad_pkg.sv
// Shared constants and the frame builder for the SNES pad responder.
// Optional GameTank frame support is enabled by defining SNES_PAD_GAMETANK_EN.
package snes_pad_pkg;

    localparam int FRAME_LEN = 16;
    localparam logic FILL_LEVEL = 1'b0;

    // Wire bits 13..16 of a SNES frame (standard pad ID: all released)
    localparam logic [3:0] SNES_ID_BITS = 4'b1111;
    // Wire bits 9..12 and 13..16 of a GameTank frame
    localparam logic [3:0] GT_PAD_BITS  = 4'b1111;
    localparam logic [3:0] GT_ID_BITS   = 4'b0000;

    // Button indices into the 12-bit buttons vector
    localparam int BTN_B      = 0;
    localparam int BTN_Y      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DN     = 5;
    localparam int BTN_LT     = 6;
    localparam int BTN_RT     = 7;
    localparam int BTN_A      = 8;
    localparam int BTN_X      = 9;
    localparam int BTN_L      = 10;
    localparam int BTN_R      = 11;

    typedef enum logic {
        FRAME_SNES     = 1'b0,
        FRAME_GAMETANK = 1'b1
    } frame_kind_e;

    // Frame word with bit 0 = wire bit 1; buttons are active-low on the wire.
    function automatic logic [15:0] build_frame(input logic [11:0] buttons,
                                                input frame_kind_e kind);
        logic [15:0] word;
        if (kind == FRAME_GAMETANK) begin
            word = {GT_ID_BITS, GT_PAD_BITS, ~buttons[BTN_RT:BTN_B]};
        end else begin
            word = {SNES_ID_BITS, ~buttons[BTN_R:BTN_B]};
        end
        return word;
    endfunction

endpackage

// File: rtl/snes_pad_responder_filter.sv
// pad_in_filter: 2-FF synchronizer followed by a glitch filter. The filtered
// level only follows the synchronized pin after FILT_CYCLES consecutive
// cycles of disagreement; any shorter excursion restarts the count.
module pad_in_filter #(
    parameter int   FILT_CYCLES = 3,
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic level
);

    logic       meta_q, meta_d;
    logic       sync_q, sync_d;
    logic       level_q, level_d;
    logic [3:0] cnt_q, cnt_d;

    // Synchronizer chain and disagreement counter
    always_comb begin
        meta_d  = pin;
        sync_d  = meta_q;
        level_d = level_q;
        cnt_d   = 4'd0;
        if (sync_q != level_q) begin
            if (cnt_q == 4'(FILT_CYCLES - 1)) begin
                level_d = sync_q;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    // State registers, reset to the pin's idle level
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q  <= RESET_LEVEL;
            sync_q  <= RESET_LEVEL;
            level_q <= RESET_LEVEL;
            cnt_q   <= 4'd0;
        end else begin
            meta_q  <= meta_d;
            sync_q  <= sync_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;

endmodule

// File: rtl/snes_pad_responder.sv
// SNES controller responder: latches the button word on the console strobe
// and shifts it out on joy_clk rising edges. Define SNES_PAD_GAMETANK_EN to
// add the gametank_mode input and the alternative GameTank frame layout.
module snes_pad_responder
    import snes_pad_pkg::*;
#(
    parameter int FILT_CYCLES = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        joy_strb,
    input  logic        joy_clk,
    input  logic [11:0] buttons,
`ifdef SNES_PAD_GAMETANK_EN
    input  logic        gametank_mode,
`endif
    output logic        joy_data,
    output logic        frame_done,
    output logic        busy
);

    localparam logic [4:0] LAST_CNT = 5'(FRAME_LEN);
    localparam logic [4:0] PRE_LAST = 5'(FRAME_LEN - 1);

    logic        strb_lvl, clk_lvl, clk_rise;
    frame_kind_e kind;

    logic [15:0] shift_q, shift_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        armed_q, armed_d;
    logic        clk_prev_q, clk_prev_d;
    logic        frame_done_q, frame_done_d;
    logic        busy_q, busy_d;

    pad_in_filter #(.FILT_CYCLES(FILT_CYCLES), .RESET_LEVEL(1'b0)) u_strb_filt (
        .clk   (clk),
        .reset (reset),
        .pin   (joy_strb),
        .level (strb_lvl)
    );

    pad_in_filter #(.FILT_CYCLES(FILT_CYCLES), .RESET_LEVEL(1'b1)) u_clk_filt (
        .clk   (clk),
        .reset (reset),
        .pin   (joy_clk),
        .level (clk_lvl)
    );

`ifdef SNES_PAD_GAMETANK_EN
    assign kind = gametank_mode ? FRAME_GAMETANK : FRAME_SNES;
`else
    assign kind = FRAME_SNES;
`endif

    assign clk_rise = clk_lvl & ~clk_prev_q;

    // Latch/shift control: strobe has priority over clock edges; a frame
    // only shifts after a latch since reset (armed) and stops at 16 bits.
    always_comb begin
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        armed_d      = armed_q;
        clk_prev_d   = clk_lvl;
        frame_done_d = 1'b0;
        if (strb_lvl) begin
            shift_d = build_frame(buttons, kind);
            cnt_d   = 5'd0;
            armed_d = 1'b1;
        end else if (clk_rise && armed_q && (cnt_q != LAST_CNT)) begin
            shift_d      = {FILL_LEVEL, shift_q[15:1]};
            cnt_d        = cnt_q + 5'd1;
            frame_done_d = (cnt_q == PRE_LAST);
        end
        busy_d = (cnt_d != 5'd0) && (cnt_d != LAST_CNT);
    end

    // Frame state and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q      <= '1;
            cnt_q        <= 5'd0;
            armed_q      <= 1'b0;
            clk_prev_q   <= 1'b1;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            armed_q      <= armed_d;
            clk_prev_q   <= clk_prev_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
        end
    end

    // Bit 0 of the shift register is the wire bit currently presented
    assign joy_data   = shift_q[0];
    assign frame_done = frame_done_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_snes_pad_responder.sv
// Directed testbench for snes_pad_responder (FILT_CYCLES = 3).
module tb_snes_pad_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        joy_strb;
    logic        joy_clk;
    logic [11:0] buttons;
    logic        gametank_mode;
    logic        joy_data;
    logic        frame_done;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;
    int fd_total = 0;
    logic busy_mid;

    snes_pad_responder #(.FILT_CYCLES(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .joy_strb     (joy_strb),
        .joy_clk      (joy_clk),
        .buttons      (buttons),
`ifdef SNES_PAD_GAMETANK_EN
        .gametank_mode(gametank_mode),
`endif
        .joy_data     (joy_data),
        .frame_done   (frame_done),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done === 1'b1) fd_total++;
    end

    typedef struct {
        logic [11:0] btn;
        logic        glitch;
        logic [15:0] exp_inv;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Latch, then read wire bits 1..20 (bit n-1 of w = wire bit n)
    task automatic read_frame(input logic [11:0] b, input logic glitch, output logic [19:0] w);
        buttons  = b;
        joy_strb = 1'b1;
        cycles(20);
        joy_strb = 1'b0;
        cycles(20);
        @(negedge clk);
        w[0] = joy_data;
        for (int i = 1; i < 20; i++) begin
            joy_clk = 1'b0;
            cycles(10);
            @(negedge clk);
            check("fall_hold", {31'd0, joy_data}, {31'd0, w[i-1]});
            joy_clk = 1'b1;
            cycles(10);
            if (glitch && i == 8) begin
                joy_clk = 1'b0;
                cycles(2);
                joy_clk = 1'b1;
                cycles(10);
            end
            @(negedge clk);
            w[i] = joy_data;
            if (i == 5) busy_mid = busy;
        end
    endtask

    task automatic clk_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            joy_clk = 1'b0;
            cycles(10);
            joy_clk = 1'b1;
            cycles(10);
        end
    endtask

    initial begin
        logic [19:0] w;
        int fd0;
        int lat;

        vecs[0] = '{btn: 12'h001, glitch: 1'b0, exp_inv: 16'h0001};
        vecs[1] = '{btn: 12'hA5A, glitch: 1'b1, exp_inv: 16'h0A5A};
        vecs[2] = '{btn: 12'hFFF, glitch: 1'b0, exp_inv: 16'h0FFF};
        vecs[3] = '{btn: 12'h000, glitch: 1'b0, exp_inv: 16'h0000};
        vecs[4] = '{btn: 12'h800, glitch: 1'b1, exp_inv: 16'h0800};

        reset = 1'b1;
        joy_strb = 1'b0;
        joy_clk = 1'b1;
        buttons = 12'h000;
        gametank_mode = 1'b0;
        cycles(5);
        @(negedge clk);
        check("rst_joy_data", {31'd0, joy_data}, 32'd1);
        check("rst_frame_done", {31'd0, frame_done}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        cycles(5);

        // Clock edges before any latch must not shift
        clk_pulses(3);
        @(negedge clk);
        check("no_latch_joy_data", {31'd0, joy_data}, 32'd1);
        check("no_latch_busy", {31'd0, busy}, 32'd0);

        // Table-driven frames
        for (int v = 0; v < 5; v++) begin
            fd0 = fd_total;
            read_frame(vecs[v].btn, vecs[v].glitch, w);
            check($sformatf("word_%0d", v), {16'd0, ~w[15:0]}, {16'd0, vecs[v].exp_inv});
            check($sformatf("fill_%0d", v), {28'd0, w[19:16]}, 32'd0);
            check($sformatf("fd_cnt_%0d", v), fd_total - fd0, 32'd1);
            check($sformatf("busy_mid_%0d", v), {31'd0, busy_mid}, 32'd1);
            check($sformatf("busy_end_%0d", v), {31'd0, busy}, 32'd0);
        end

        // Strobe pin to joy_data latency (joy_data currently fill 0)
        buttons = 12'h000;
        @(negedge clk);
        joy_strb = 1'b1;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (joy_data === 1'b1 && lat == 0) lat = k;
        end
        check("strb_latency", lat, 32'd6);
        // Live buttons[0] during latch, one register delay
        buttons = 12'h001;
        check("latch_follow_pre", {31'd0, joy_data}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("latch_follow_0", {31'd0, joy_data}, 32'd0);
        buttons = 12'h000;
        @(posedge clk);
        @(negedge clk);
        check("latch_follow_1", {31'd0, joy_data}, 32'd1);

        // Freeze on strobe fall, then clock pin latency
        buttons = 12'h002;
        cycles(3);
        joy_strb = 1'b0;
        cycles(20);
        buttons = 12'h001;
        cycles(10);
        @(negedge clk);
        check("freeze", {31'd0, joy_data}, 32'd1);
        joy_clk = 1'b0;
        cycles(10);
        @(negedge clk);
        joy_clk = 1'b1;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (joy_data === 1'b0 && lat == 0) lat = k;
        end
        check("clk_latency", lat, 32'd6);

        // Abort after 7 edges; clock edges while strobe high ignored
        fd0 = fd_total;
        buttons = 12'h3C3;
        joy_strb = 1'b1;
        cycles(20);
        joy_strb = 1'b0;
        cycles(20);
        clk_pulses(7);
        @(negedge clk);
        check("abort_busy_before", {31'd0, busy}, 32'd1);
        joy_strb = 1'b1;
        cycles(20);
        @(negedge clk);
        check("abort_busy_strb", {31'd0, busy}, 32'd0);
        clk_pulses(2);
        @(negedge clk);
        check("strb_clk_ignored", {31'd0, joy_data}, 32'd0);
        joy_strb = 1'b0;
        cycles(20);
        check("abort_no_fd", fd_total - fd0, 32'd0);
        fd0 = fd_total;
        read_frame(12'h3C3, 1'b0, w);
        check("abort_next_word", {16'd0, ~w[15:0]}, 32'h03C3);
        check("abort_next_fd", fd_total - fd0, 32'd1);

        // Reset mid-frame abandons the frame
        fd0 = fd_total;
        buttons = 12'h001;
        joy_strb = 1'b1;
        cycles(20);
        joy_strb = 1'b0;
        cycles(20);
        clk_pulses(5);
        reset = 1'b1;
        cycles(3);
        @(negedge clk);
        check("midrst_joy_data", {31'd0, joy_data}, 32'd1);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        cycles(5);
        clk_pulses(12);
        @(negedge clk);
        check("postrst_joy_data", {31'd0, joy_data}, 32'd1);
        check("postrst_busy", {31'd0, busy}, 32'd0);
        check("postrst_no_fd", fd_total - fd0, 32'd0);

`ifdef SNES_PAD_GAMETANK_EN
        gametank_mode = 1'b1;
        fd0 = fd_total;
        read_frame(12'hF81, 1'b0, w);
        check("gt_word", {12'd0, w}, 32'h00F7E);
        check("gt_fd", fd_total - fd0, 32'd1);
        buttons = 12'hF81;
        joy_strb = 1'b1;
        cycles(20);
        joy_strb = 1'b0;
        cycles(20);
        clk_pulses(4);
        reset = 1'b1;
        cycles(3);
        reset = 1'b0;
        cycles(5);
        clk_pulses(6);
        @(negedge clk);
        check("gt_rst_joy_data", {31'd0, joy_data}, 32'd1);
        gametank_mode = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
